// File: rtl/fir_sym_pipe.sv
// Symmetric-coefficient FIR: folded pre-adders, run-time loadable coefficients,
// fixed four-edge pipeline (taps, pre-add, multiply, sum/scale/saturate).
module fir_sym_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned TAPS   = 9,
    parameter int unsigned SHIFT  = 0,
    localparam int unsigned M     = (TAPS + 1) / 2,
    localparam int unsigned AW    = $clog2(M),
    localparam int unsigned ACC_W = DATA_W + 1 + COEF_W + $clog2(M)
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] x,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] y,
    output logic                     sat
);

    localparam int unsigned PW = DATA_W + 1;
    localparam int unsigned MW = PW + COEF_W;

    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    logic signed [DATA_W-1:0] tap_q  [TAPS];
    logic signed [COEF_W-1:0] coef_q [M];
    logic signed [PW-1:0]     p_d    [M];
    logic signed [PW-1:0]     p_q    [M];
    logic signed [MW-1:0]     m_d    [M];
    logic signed [MW-1:0]     m_q    [M];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [DATA_W-1:0] y_d, y_q;
    logic                     sat_d, sat_q;
    logic [3:0]               vld_q;

    // Delay line only moves on accepted samples, so bubbles leave the window intact.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < int'(TAPS); i++) tap_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < int'(TAPS); i++) tap_q[i] <= '0;
        end else if (in_valid) begin
            tap_q[0] <= x;
            for (int i = 1; i < int'(TAPS); i++) tap_q[i] <= tap_q[i-1];
        end
    end

    // Coefficients survive clr; only reset clears them.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < int'(M); i++) coef_q[i] <= '0;
        end else if (coef_we && (32'(coef_addr) < M)) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    for (genvar i = 0; i < int'(M) - 1; i++) begin : g_pre
        assign p_d[i] = PW'(tap_q[i]) + PW'(tap_q[TAPS-1-i]);
    end
    assign p_d[M-1] = PW'(tap_q[M-1]);

    for (genvar i = 0; i < int'(M); i++) begin : g_mul
        assign m_d[i] = MW'(p_q[i]) * MW'(coef_q[i]);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < int'(M); i++) begin
                p_q[i] <= '0;
                m_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < int'(M); i++) begin
                p_q[i] <= '0;
                m_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(M); i++) begin
                p_q[i] <= p_d[i];
                m_q[i] <= m_d[i];
            end
        end
    end

    // ACC_W leaves room for M full-width products, so the sum never wraps.
    always_comb begin
        acc = '0;
        for (int i = 0; i < int'(M); i++) acc = acc + ACC_W'(m_q[i]);
        scaled = acc >>> SHIFT;
        y_d    = scaled[DATA_W-1:0];
        sat_d  = 1'b0;
        if (scaled > Y_MAX) begin
            y_d   = Y_MAX[DATA_W-1:0];
            sat_d = 1'b1;
        end else if (scaled < Y_MIN) begin
            y_d   = Y_MIN[DATA_W-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            y_q   <= '0;
            sat_q <= 1'b0;
            vld_q <= '0;
        end else if (clr) begin
            y_q   <= '0;
            sat_q <= 1'b0;
            vld_q <= '0;
        end else begin
            y_q   <= y_d;
            sat_q <= sat_d;
            vld_q <= {vld_q[2:0], in_valid};
        end
    end

    assign out_valid = vld_q[3];
    assign y         = y_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_fir_sym_pipe.sv
// Bench for fir_sym_pipe: table-driven impulse, directed corner sequences and a
// randomized stream checked against a convolution model, at SHIFT=0 and SHIFT=4.
module tb_fir_sym_pipe;
    localparam int NT = 9;
    localparam int NM = 5;
    localparam int NC = 2048;

    logic clk = 1'b0;
    logic rstN, clr, in_valid, coef_we;
    logic signed [15:0] x, coef_data;
    logic [2:0] coef_addr;
    logic ov0, sat0, ov4, sat4;
    logic signed [15:0] y0, y4;

    int nvec = 0;
    int nerr = 0;
    int k = 0;

    logic signed [15:0] tm [NT];
    logic signed [15:0] cm [NM];
    logic signed [15:0] tsnap [NC][NT];
    logic signed [15:0] csnap [NC][NM];
    bit acc_e [NC];
    int obs0 [$];
    int obs4 [$];
    int imp [9];

    typedef struct {
        logic iv;
        int   xv;
        logic ev;
        int   ey;
    } vec_t;
    vec_t tbl [14];

    always #5 clk = ~clk;

    fir_sym_pipe #(.DATA_W(16), .COEF_W(16), .TAPS(9), .SHIFT(0)) dut0 (
        .clk(clk), .rstN(rstN), .clr(clr), .in_valid(in_valid), .x(x),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov0), .y(y0), .sat(sat0)
    );

    fir_sym_pipe #(.DATA_W(16), .COEF_W(16), .TAPS(9), .SHIFT(4)) dut4 (
        .clk(clk), .rstN(rstN), .clr(clr), .in_valid(in_valid), .x(x),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov4), .y(y4), .sat(sat4)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    // Plain convolution: tap j is weighted by coef[min(j, NT-1-j)].
    function automatic void model_out(input int kk, input int sh, output longint ey,
                                      output logic es);
        longint s;
        longint t;
        int ci;
        s = 0;
        for (int j = 0; j < NT; j++) begin
            ci = (j < NM) ? j : NT - 1 - j;
            s += longint'(tsnap[kk-3][j]) * longint'(csnap[kk-2][ci]);
        end
        t = s >>> sh;
        if (t > 32767) begin
            ey = 32767;
            es = 1'b1;
        end else if (t < -32768) begin
            ey = -32768;
            es = 1'b1;
        end else begin
            ey = t;
            es = 1'b0;
        end
    endfunction

    task automatic drop(input int kk);
        for (int d = 0; d < 4; d++) if (kk - d >= 0) acc_e[kk-d] = 1'b0;
    endtask

    task automatic cyc(input logic rs, input logic cl, input logic iv,
                       input logic signed [15:0] xv, input logic we,
                       input logic [2:0] ad, input logic signed [15:0] dt);
        longint ey;
        logic es;
        logic exp_v;
        rstN = rs; clr = cl; in_valid = iv; x = xv;
        coef_we = we; coef_addr = ad; coef_data = dt;
        if (!rs) begin
            #1;
            chk("async_rst_y", y0, 0);
            chk("async_rst_ov", ov0, 0);
            chk("async_rst_sat", sat0, 0);
            chk("async_rst_y_s4", y4, 0);
            chk("async_rst_ov_s4", ov4, 0);
        end
        @(posedge clk);
        k++;
        if (k >= NC) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", k, NC - 1);
            $fatal(1);
        end
        if (!rs) begin
            for (int i = 0; i < NT; i++) tm[i] = '0;
            for (int i = 0; i < NM; i++) cm[i] = '0;
            acc_e[k] = 1'b0;
            drop(k);
        end else begin
            if (we && ad < NM) cm[ad] = dt;
            if (cl) begin
                for (int i = 0; i < NT; i++) tm[i] = '0;
                acc_e[k] = 1'b0;
                drop(k);
            end else if (iv) begin
                for (int i = NT - 1; i > 0; i--) tm[i] = tm[i-1];
                tm[0] = xv;
                acc_e[k] = 1'b1;
            end else begin
                acc_e[k] = 1'b0;
            end
        end
        for (int i = 0; i < NT; i++) tsnap[k][i] = tm[i];
        for (int i = 0; i < NM; i++) csnap[k][i] = cm[i];
        #1;
        exp_v = (k >= 4) ? acc_e[k-3] : 1'b0;
        chk("out_valid", ov0, exp_v);
        chk("out_valid_s4", ov4, exp_v);
        if (exp_v) begin
            model_out(k, 0, ey, es);
            chk("y", y0, ey);
            chk("sat", sat0, es);
            model_out(k, 4, ey, es);
            chk("y_s4", y4, ey);
            chk("sat_s4", sat4, es);
        end
        if (ov0) obs0.push_back(int'(y0));
        if (ov4) obs4.push_back(int'(y4));
    endtask

    task automatic smp(input logic iv, input logic signed [15:0] xv);
        cyc(1'b1, 1'b0, iv, xv, 1'b0, 3'd0, 16'sd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic signed [15:0] d);
        cyc(1'b1, 1'b0, 1'b0, 16'sd0, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) smp(1'b0, 16'sd0);
    endtask

    task automatic impulse(input logic signed [15:0] amp);
        smp(1'b1, amp);
        repeat (8) smp(1'b1, 16'sd0);
        idle(6);
    endtask

    initial begin
        rstN = 1'b1; clr = 1'b0; in_valid = 1'b0; x = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        imp = '{-106, 20, -16, 12, 6, 12, -16, 20, -106};
        for (int r = 0; r < 14; r++) begin
            tbl[r].iv = (r < 9);
            tbl[r].xv = (r == 0) ? 1 : 0;
            tbl[r].ev = (r >= 3 && r <= 11);
            tbl[r].ey = 0;
            if (r >= 3 && r <= 11) tbl[r].ey = imp[r-3];
        end
        #2;

        cyc(1'b0, 1'b0, 1'b0, 16'sd0, 1'b0, 3'd0, 16'sd0);
        cyc(1'b0, 1'b0, 1'b0, 16'sd0, 1'b0, 3'd0, 16'sd0);
        idle(2);

        // Impulse from the table.
        for (int i = 0; i < NM; i++) wr(3'(i), 16'(imp[i]));
        idle(4);
        for (int r = 0; r < 14; r++) begin
            smp(tbl[r].iv, 16'(tbl[r].xv));
            chk("tbl_ov", ov0, tbl[r].ev);
            if (tbl[r].ev) chk("tbl_y", y0, tbl[r].ey);
            chk("tbl_sat", sat0, 0);
        end

        // Impulse with random bubbles.
        obs0.delete();
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, 2)) smp(1'b0, 16'sd0);
            smp(1'b1, (i == 0) ? 16'sd1 : 16'sd0);
        end
        idle(6);
        chk("bub_count", obs0.size(), 9);
        for (int i = 0; i < 9; i++) if (i < obs0.size()) chk("bub_y", obs0[i], imp[i]);

        // Scaling at SHIFT=4 with centre coefficient -3.
        for (int i = 0; i < 4; i++) wr(3'(i), 16'sd0);
        wr(3'd4, -16'sd3);
        idle(4);
        obs4.delete();
        impulse(16'sd16);
        chk("scale_x16", (obs4.size() > 4) ? obs4[4] : 99999, -3);
        obs4.delete();
        impulse(16'sd1);
        chk("scale_x1_floor", (obs4.size() > 4) ? obs4[4] : 99999, -1);

        // Saturation both ways.
        for (int i = 0; i < NM; i++) wr(3'(i), 16'sd1000);
        repeat (12) smp(1'b1, 16'sd32767);
        chk("sat_pos_y", y0, 32767);
        chk("sat_pos_flag", sat0, 1);
        chk("sat_pos_y_s4", y4, 32767);
        repeat (12) smp(1'b1, -16'sd32768);
        chk("sat_neg_y", y0, -32768);
        chk("sat_neg_flag", sat0, 1);
        chk("sat_neg_flag_s4", sat4, 1);
        idle(5);

        // Live coefficient write under DC input.
        for (int i = 0; i < NM; i++) wr(3'(i), 16'(imp[i]));
        repeat (14) smp(1'b1, 16'sd1);
        chk("dc_before", y0, -174);
        cyc(1'b1, 1'b0, 1'b1, 16'sd1, 1'b1, 3'd4, 16'sd10);
        chk("dc_c1", y0, -174);
        smp(1'b1, 16'sd1);
        chk("dc_c2", y0, -174);
        smp(1'b1, 16'sd1);
        chk("dc_c3", y0, -170);
        smp(1'b1, 16'sd1);
        chk("dc_c4", y0, -170);
        wr(3'd4, 16'sd6);
        idle(5);

        // clr mid-stream: outputs flushed, coefficients kept.
        repeat (8) smp(1'b1, 16'($urandom));
        cyc(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0, 3'd0, 16'sd0);
        chk("clr_y", y0, 0);
        chk("clr_ov", ov0, 0);
        chk("clr_sat", sat0, 0);
        idle(3);
        obs0.delete();
        impulse(16'sd1);
        chk("clr_count", obs0.size(), 9);
        for (int i = 0; i < 9; i++) if (i < obs0.size()) chk("clr_keep_coef", obs0[i], imp[i]);

        // Reset mid-stream: coefficients cleared.
        repeat (6) smp(1'b1, 16'($urandom));
        cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0, 3'd0, 16'sd0);
        idle(2);
        obs0.delete();
        impulse(16'sd1000);
        chk("rst_count", obs0.size(), 9);
        for (int i = 0; i < 9; i++) if (i < obs0.size()) chk("rst_coef_zero", obs0[i], 0);

        // Randomized stream with bubbles, live writes (some out of range) and clr.
        for (int i = 0; i < NM; i++) wr(3'(i), 16'($urandom));
        repeat (400) begin
            cyc(1'b1, ($urandom % 50) == 0, ($urandom % 4) != 0, 16'($urandom),
                ($urandom % 8) == 0, 3'($urandom), 16'($urandom));
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
